// File: rtl/otp_display_decoder_if.sv
// Display bus shared by the OTP authenticator core and its receive-side decoder,
// plus the decoded results and an FSM state view for observation.
interface otp_display_decoder_if;
   logic [6:0] lfsr_out;
   logic [6:0] user_out;
   logic [1:0] an;
   logic       otp_latch;
   logic       user_latch;

   // otp_valid/user_valid are levels with no ready: each rises on the edge that
   // captures the second digit and stays up until a latch rise clears it.
   logic [7:0] otp_code;
   logic [7:0] user_code;
   logic       otp_valid;
   logic       user_valid;
   logic       match;
   logic       mismatch;
   logic       seg_err;
   logic       seq_err;
   logic       timeout;
   logic [2:0] fsm_state;

   modport master (
      output lfsr_out, user_out, an, otp_latch, user_latch,
      input  otp_code, user_code, otp_valid, user_valid, match, mismatch,
             seg_err, seq_err, timeout, fsm_state
   );

   modport slave (
      input  lfsr_out, user_out, an, otp_latch, user_latch,
      output otp_code, user_code, otp_valid, user_valid, match, mismatch,
             seg_err, seq_err, timeout, fsm_state
   );
endinterface

// File: rtl/otp_display_decoder.sv
// Rebuilds the OTP and user codes from the multiplexed seven-segment bus and
// reports match/mismatch after each user entry.
module otp_display_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   otp_display_decoder_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      CAPTURE_OTP  = 3'd1,
      CAPTURE_USER = 3'd2,
      COMPARE      = 3'd3,
      DONE         = 3'd4
   } state_t;

   localparam logic [7:0]  STABLE_LIMIT  = 8'(STABLE_CYCLES);
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
   localparam logic [6:0]  BLANK         = 7'h7F;
   localparam logic [1:0]  AN_DIGIT0     = 2'b10;
   localparam logic [1:0]  AN_DIGIT1     = 2'b01;

   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h40:   r = {1'b1, 4'h0};
         7'h79:   r = {1'b1, 4'h1};
         7'h24:   r = {1'b1, 4'h2};
         7'h30:   r = {1'b1, 4'h3};
         7'h19:   r = {1'b1, 4'h4};
         7'h12:   r = {1'b1, 4'h5};
         7'h02:   r = {1'b1, 4'h6};
         7'h78:   r = {1'b1, 4'h7};
         7'h00:   r = {1'b1, 4'h8};
         7'h10:   r = {1'b1, 4'h9};
         7'h08:   r = {1'b1, 4'hA};
         7'h03:   r = {1'b1, 4'hB};
         7'h46:   r = {1'b1, 4'hC};
         7'h21:   r = {1'b1, 4'hD};
         7'h06:   r = {1'b1, 4'hE};
         7'h0E:   r = {1'b1, 4'hF};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   state_t     state, state_next;

   logic [6:0] lfsr_q, user_q;
   logic [1:0] an_q;
   logic       otp_latch_q, user_latch_q, otp_latch_d, user_latch_d;
   logic       otp_rise, user_rise;

   logic [6:0] seg_sel;
   logic [8:0] pair, pair_prev;
   logic [7:0] stab_cnt, stab_next;
   logic       stable_hit;

   logic [4:0] glyph_info;
   logic       glyph_ok;
   logic [3:0] glyph_val;
   logic       capture_active, accept, wr_d0, wr_d1, bad_glyph;

   logic [15:0] tcnt, tcnt_n, tcnt_inc;
   logic        tmo_hit;

   logic [3:0] otp_d0, otp_d1, user_d0, user_d1;
   logic [3:0] otp_d0_n, otp_d1_n, user_d0_n, user_d1_n;
   logic       otp_f0, otp_f1, user_f0, user_f1, user_active;
   logic       otp_f0_n, otp_f1_n, user_f0_n, user_f1_n, user_active_n;
   logic       otp_valid, user_valid, match, mismatch, seg_err, seq_err, timeout;
   logic       otp_valid_n, user_valid_n, match_n, mismatch_n;
   logic       seg_err_n, seq_err_n, timeout_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q       <= '0;
         user_q       <= '0;
         an_q         <= '0;
         otp_latch_q  <= 1'b0;
         user_latch_q <= 1'b0;
         otp_latch_d  <= 1'b0;
         user_latch_d <= 1'b0;
      end else begin
         lfsr_q       <= bus.lfsr_out;
         user_q       <= bus.user_out;
         an_q         <= bus.an;
         otp_latch_q  <= bus.otp_latch;
         user_latch_q <= bus.user_latch;
         otp_latch_d  <= otp_latch_q;
         user_latch_d <= user_latch_q;
      end
   end

   assign otp_rise  = otp_latch_q & ~otp_latch_d;
   assign user_rise = user_latch_q & ~user_latch_d;

   // The window restarts on any change of the selected digit or its pattern.
   assign seg_sel = (state == CAPTURE_USER) ? user_q : lfsr_q;
   assign pair    = {an_q, seg_sel};

   always_comb begin
      stab_next = stab_cnt;
      if (an_q == 2'b11 || an_q == 2'b00) begin
         stab_next = 8'd0;
      end else if (pair != pair_prev) begin
         stab_next = 8'd1;
      end else if (stab_cnt != 8'hFF) begin
         stab_next = stab_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stab_cnt  <= '0;
         pair_prev <= '0;
      end else begin
         stab_cnt  <= stab_next;
         pair_prev <= pair;
      end
   end

   // Edge on the limit so a saturated counter at 255 does not re-accept.
   assign stable_hit = (stab_next == STABLE_LIMIT) && (stab_cnt != STABLE_LIMIT);

   assign glyph_info     = decode_glyph(seg_sel);
   assign glyph_ok       = glyph_info[4];
   assign glyph_val      = glyph_info[3:0];
   assign capture_active = (state == CAPTURE_OTP) || ((state == CAPTURE_USER) && user_active);
   assign accept         = stable_hit && capture_active && !otp_rise;
   assign wr_d0          = accept && glyph_ok && (an_q == AN_DIGIT0);
   assign wr_d1          = accept && glyph_ok && (an_q == AN_DIGIT1);
   assign bad_glyph      = accept && !glyph_ok && (seg_sel != BLANK);

   assign tcnt_inc = tcnt + 16'd1;
   assign tmo_hit  = capture_active && (tcnt_inc == TIMEOUT_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next    = state;
      otp_d0_n      = otp_d0;
      otp_d1_n      = otp_d1;
      user_d0_n     = user_d0;
      user_d1_n     = user_d1;
      otp_f0_n      = otp_f0;
      otp_f1_n      = otp_f1;
      user_f0_n     = user_f0;
      user_f1_n     = user_f1;
      user_active_n = user_active;
      otp_valid_n   = otp_valid;
      user_valid_n  = user_valid;
      match_n       = match;
      mismatch_n    = mismatch;
      seg_err_n     = seg_err;
      seq_err_n     = seq_err;
      timeout_n     = 1'b0;
      tcnt_n        = capture_active ? tcnt_inc : tcnt;

      if (otp_rise) begin
         state_next    = CAPTURE_OTP;
         otp_f0_n      = 1'b0;
         otp_f1_n      = 1'b0;
         user_f0_n     = 1'b0;
         user_f1_n     = 1'b0;
         user_active_n = 1'b0;
         otp_valid_n   = 1'b0;
         user_valid_n  = 1'b0;
         match_n       = 1'b0;
         mismatch_n    = 1'b0;
         seg_err_n     = 1'b0;
         seq_err_n     = 1'b0;
         tcnt_n        = '0;
      end else begin
         if (bad_glyph) seg_err_n = 1'b1;
         // A user entry is only welcome while waiting for one or after a result.
         if (user_rise && (state != DONE) && !((state == CAPTURE_USER) && !user_active))
            seq_err_n = 1'b1;

         case (state)
            IDLE: ;
            CAPTURE_OTP: begin
               if (wr_d0) begin otp_d0_n = glyph_val; otp_f0_n = 1'b1; end
               if (wr_d1) begin otp_d1_n = glyph_val; otp_f1_n = 1'b1; end
               if (otp_f0_n && otp_f1_n) begin
                  otp_valid_n = 1'b1;
                  state_next  = CAPTURE_USER;
               end else if (tmo_hit) begin
                  timeout_n  = 1'b1;
                  state_next = IDLE;
                  otp_f0_n   = 1'b0;
                  otp_f1_n   = 1'b0;
                  tcnt_n     = '0;
               end
            end
            CAPTURE_USER: begin
               if (!user_active) begin
                  if (user_rise) begin
                     user_active_n = 1'b1;
                     user_f0_n     = 1'b0;
                     user_f1_n     = 1'b0;
                     user_valid_n  = 1'b0;
                     tcnt_n        = '0;
                  end
               end else begin
                  if (wr_d0) begin user_d0_n = glyph_val; user_f0_n = 1'b1; end
                  if (wr_d1) begin user_d1_n = glyph_val; user_f1_n = 1'b1; end
                  if (user_f0_n && user_f1_n) begin
                     user_valid_n  = 1'b1;
                     user_active_n = 1'b0;
                     state_next    = COMPARE;
                  end else if (tmo_hit) begin
                     timeout_n     = 1'b1;
                     state_next    = IDLE;
                     user_f0_n     = 1'b0;
                     user_f1_n     = 1'b0;
                     user_active_n = 1'b0;
                     tcnt_n        = '0;
                  end
               end
            end
            COMPARE: begin
               match_n    = ({user_d1, user_d0} == {otp_d1, otp_d0});
               mismatch_n = ({user_d1, user_d0} != {otp_d1, otp_d0});
               state_next = DONE;
            end
            DONE: begin
               if (user_rise) begin
                  state_next    = CAPTURE_USER;
                  user_active_n = 1'b1;
                  user_f0_n     = 1'b0;
                  user_f1_n     = 1'b0;
                  user_valid_n  = 1'b0;
                  match_n       = 1'b0;
                  mismatch_n    = 1'b0;
                  tcnt_n        = '0;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         otp_d0      <= '0;
         otp_d1      <= '0;
         user_d0     <= '0;
         user_d1     <= '0;
         otp_f0      <= 1'b0;
         otp_f1      <= 1'b0;
         user_f0     <= 1'b0;
         user_f1     <= 1'b0;
         user_active <= 1'b0;
         otp_valid   <= 1'b0;
         user_valid  <= 1'b0;
         match       <= 1'b0;
         mismatch    <= 1'b0;
         seg_err     <= 1'b0;
         seq_err     <= 1'b0;
         timeout     <= 1'b0;
         tcnt        <= '0;
      end else begin
         otp_d0      <= otp_d0_n;
         otp_d1      <= otp_d1_n;
         user_d0     <= user_d0_n;
         user_d1     <= user_d1_n;
         otp_f0      <= otp_f0_n;
         otp_f1      <= otp_f1_n;
         user_f0     <= user_f0_n;
         user_f1     <= user_f1_n;
         user_active <= user_active_n;
         otp_valid   <= otp_valid_n;
         user_valid  <= user_valid_n;
         match       <= match_n;
         mismatch    <= mismatch_n;
         seg_err     <= seg_err_n;
         seq_err     <= seq_err_n;
         timeout     <= timeout_n;
         tcnt        <= tcnt_n;
      end
   end

   assign bus.otp_code   = {otp_d1, otp_d0};
   assign bus.user_code  = {user_d1, user_d0};
   assign bus.otp_valid  = otp_valid;
   assign bus.user_valid = user_valid;
   assign bus.match      = match;
   assign bus.mismatch   = mismatch;
   assign bus.seg_err    = seg_err;
   assign bus.seq_err    = seq_err;
   assign bus.timeout    = timeout;
   assign bus.fsm_state  = state;
endmodule

// File: tb/tb_otp_display_decoder.sv
// Bench for otp_display_decoder: directed sequences, a glyph vector table and
// randomized entries scored against a digit-window model.
module tb_otp_display_decoder;
   localparam int STABLE = 4;
   localparam int TMO    = 100;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_OTP  = 3'd1;
   localparam logic [2:0] S_USER = 3'd2;
   localparam logic [2:0] S_CMP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   otp_display_decoder_if bus();

   otp_display_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      logic [6:0] seg0;
      logic [6:0] seg1;
      logic [7:0] code;
      logic       valid;
      logic       seg_err;
   } vec_t;
   vec_t vecs[19];

   typedef struct {
      logic [1:0] an;
      logic [3:0] nib;
      int         hold;
   } burst_t;
   burst_t bursts[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [22:0] outs();
      return {bus.otp_code, bus.user_code, bus.otp_valid, bus.user_valid, bus.match,
              bus.mismatch, bus.seg_err, bus.seq_err, bus.timeout};
   endfunction

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic o, input logic u);
      bus.otp_latch = o; bus.user_latch = u;
      tick(1);
      bus.otp_latch = 1'b0; bus.user_latch = 1'b0;
      tick(1);
   endtask

   task automatic show(input bit usr, input logic [1:0] a, input logic [6:0] s, input int n);
      if (usr) bus.user_out = s; else bus.lfsr_out = s;
      bus.an = a;
      tick(n);
      bus.an = 2'b11;
      tick(1);
   endtask

   task automatic drive_bursts(input bit usr);
      foreach (bursts[i]) show(usr, bursts[i].an, glyph[bursts[i].nib], bursts[i].hold);
   endtask

   task automatic gen_bursts(input logic [3:0] d0, input logic [3:0] d1);
      burst_t b;
      int n;
      bursts.delete();
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
         b.an   = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
         b.nib  = 4'($urandom_range(0, 15));
         b.hold = $urandom_range(2, STABLE + 2);
         bursts.push_back(b);
      end
      b.an = 2'b10; b.nib = d0; b.hold = STABLE + 1; bursts.push_back(b);
      b.an = 2'b01; b.nib = d1; b.hold = STABLE + 1; bursts.push_back(b);
   endtask

   // Model: a burst held at least STABLE cycles writes its digit; the phase
   // ends the moment both digits have been written.
   function automatic logic [8:0] model_phase();
      logic [3:0] dig [2];
      bit got [2];
      int idx;
      dig[0] = '0; dig[1] = '0; got[0] = 0; got[1] = 0;
      foreach (bursts[i]) begin
         if (bursts[i].hold >= STABLE) begin
            idx = (bursts[i].an == 2'b10) ? 0 : 1;
            dig[idx] = bursts[i].nib;
            got[idx] = 1;
            if (got[0] && got[1]) return {1'b1, dig[1], dig[0]};
         end
      end
      return 9'd0;
   endfunction

   initial begin
      int k;
      logic [8:0] r_otp, r_usr;
      logic [3:0] u0, u1;

      vecs[0]  = '{7'h40, 7'h0E, 8'hF0, 1'b1, 1'b0};
      vecs[1]  = '{7'h79, 7'h06, 8'hE1, 1'b1, 1'b0};
      vecs[2]  = '{7'h24, 7'h21, 8'hD2, 1'b1, 1'b0};
      vecs[3]  = '{7'h30, 7'h46, 8'hC3, 1'b1, 1'b0};
      vecs[4]  = '{7'h19, 7'h03, 8'hB4, 1'b1, 1'b0};
      vecs[5]  = '{7'h12, 7'h08, 8'hA5, 1'b1, 1'b0};
      vecs[6]  = '{7'h02, 7'h10, 8'h96, 1'b1, 1'b0};
      vecs[7]  = '{7'h78, 7'h00, 8'h87, 1'b1, 1'b0};
      vecs[8]  = '{7'h00, 7'h78, 8'h78, 1'b1, 1'b0};
      vecs[9]  = '{7'h10, 7'h02, 8'h69, 1'b1, 1'b0};
      vecs[10] = '{7'h08, 7'h12, 8'h5A, 1'b1, 1'b0};
      vecs[11] = '{7'h03, 7'h19, 8'h4B, 1'b1, 1'b0};
      vecs[12] = '{7'h46, 7'h30, 8'h3C, 1'b1, 1'b0};
      vecs[13] = '{7'h21, 7'h24, 8'h2D, 1'b1, 1'b0};
      vecs[14] = '{7'h06, 7'h79, 8'h1E, 1'b1, 1'b0};
      vecs[15] = '{7'h0E, 7'h40, 8'h0F, 1'b1, 1'b0};
      vecs[16] = '{7'h7F, 7'h79, 8'h00, 1'b0, 1'b0};
      vecs[17] = '{7'h7E, 7'h79, 8'h00, 1'b0, 1'b1};
      vecs[18] = '{7'h01, 7'h40, 8'h00, 1'b0, 1'b1};

      reset_n = 1'b0;
      bus.lfsr_out = 7'h7F; bus.user_out = 7'h7F; bus.an = 2'b11;
      bus.otp_latch = 1'b0; bus.user_latch = 1'b0;
      tick(3);
      check("reset_outs", 32'(outs()), 0);
      check("reset_state", bus.fsm_state, S_IDLE);
      reset_n = 1'b1;
      tick(2);
      check("post_reset_outs", 32'(outs()), 0);

      // OTP then matching user entry
      pulse(1'b1, 1'b0);
      check("otp_latch_state", bus.fsm_state, S_OTP);
      show(0, 2'b10, 7'h08, 6);
      show(0, 2'b01, 7'h30, 6);
      check("t1_otp_code", bus.otp_code, 8'h3A);
      check("t1_otp_valid", bus.otp_valid, 1);
      check("t1_state_user", bus.fsm_state, S_USER);
      pulse(1'b0, 1'b1);
      show(1, 2'b10, 7'h08, 6);
      bus.user_out = 7'h30; bus.an = 2'b01;
      k = 0;
      while (k < 12 && !bus.user_valid) begin tick(1); k++; end
      check("t1_capture_latency", k, STABLE + 1);
      check("t1_match_before", bus.match, 0);
      check("t1_state_compare", bus.fsm_state, S_CMP);
      tick(1);
      check("t1_match", bus.match, 1);
      check("t1_mismatch", bus.mismatch, 0);
      check("t1_user_code", bus.user_code, 8'h3A);
      check("t1_state_done", bus.fsm_state, S_DONE);
      bus.an = 2'b11;
      tick(1);

      // mismatch and retry
      pulse(1'b0, 1'b1);
      check("t2_retry_clears_match", bus.match, 0);
      check("t2_retry_state", bus.fsm_state, S_USER);
      show(1, 2'b10, 7'h03, 6);
      show(1, 2'b01, 7'h30, 6);
      check("t2_user_code", bus.user_code, 8'h3B);
      check("t2_mismatch", bus.mismatch, 1);
      check("t2_no_match", bus.match, 0);
      check("t2_no_seq_err", bus.seq_err, 0);
      pulse(1'b0, 1'b1);
      show(1, 2'b10, 7'h08, 6);
      show(1, 2'b01, 7'h30, 6);
      check("t2_retry_match", bus.match, 1);
      check("t2_retry_mismatch", bus.mismatch, 0);

      // glitch rejection
      pulse(1'b1, 1'b0);
      show(0, 2'b10, 7'h40, STABLE - 1);
      show(0, 2'b01, 7'h79, 6);
      check("t3_glitch_valid", bus.otp_valid, 0);
      check("t3_glitch_state", bus.fsm_state, S_OTP);
      show(0, 2'b10, 7'h40, 6);
      check("t3_after_valid", bus.otp_valid, 1);
      check("t3_after_code", bus.otp_code, 8'h10);

      // illegal glyph
      pulse(1'b1, 1'b0);
      show(0, 2'b10, 7'h7E, 6);
      check("t4_seg_err", bus.seg_err, 1);
      check("t4_valid_low", bus.otp_valid, 0);
      show(0, 2'b10, 7'h12, 6);
      show(0, 2'b01, 7'h19, 6);
      check("t4_code", bus.otp_code, 8'h45);
      check("t4_valid", bus.otp_valid, 1);
      check("t4_seg_err_sticky", bus.seg_err, 1);

      // sequencing
      pulse(1'b1, 1'b1);
      check("t5_both_state", bus.fsm_state, S_OTP);
      check("t5_both_seq_err", bus.seq_err, 0);
      check("t5_seg_err_cleared", bus.seg_err, 0);
      pulse(1'b0, 1'b1);
      check("t5_seq_err", bus.seq_err, 1);
      check("t5_state_kept", bus.fsm_state, S_OTP);

      // glyph table
      for (int i = 0; i < 19; i++) begin
         pulse(1'b1, 1'b0);
         show(0, 2'b10, vecs[i].seg0, 6);
         show(0, 2'b01, vecs[i].seg1, 6);
         check($sformatf("vec%0d_valid", i), bus.otp_valid, vecs[i].valid);
         check($sformatf("vec%0d_seg_err", i), bus.seg_err, vecs[i].seg_err);
         if (vecs[i].valid) check($sformatf("vec%0d_code", i), bus.otp_code, vecs[i].code);
      end

      // timeout with an idle
      bus.an = 2'b11;
      pulse(1'b1, 1'b0);
      k = 0;
      while (k < TMO + 20 && !bus.timeout) begin tick(1); k++; end
      check("t6_timeout_cycles", k, TMO);
      check("t6_timeout_state", bus.fsm_state, S_IDLE);
      tick(1);
      check("t6_timeout_one_cycle", bus.timeout, 0);

      // randomized entries against the model
      for (int it = 0; it < 25; it++) begin
         pulse(1'b1, 1'b0);
         gen_bursts(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         r_otp = model_phase();
         exp_q.push_back(r_otp[7:0]);
         drive_bursts(0);
         check("rnd_otp_valid", bus.otp_valid, 1);
         check("rnd_otp_code", bus.otp_code, exp_q.pop_front());
         pulse(1'b0, 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            u0 = r_otp[3:0]; u1 = r_otp[7:4];
         end else begin
            u0 = 4'($urandom_range(0, 15)); u1 = 4'($urandom_range(0, 15));
         end
         gen_bursts(u0, u1);
         r_usr = model_phase();
         exp_q.push_back(r_usr[7:0]);
         drive_bursts(1);
         tick(2);
         check("rnd_user_valid", bus.user_valid, 1);
         check("rnd_user_code", bus.user_code, exp_q.pop_front());
         check("rnd_match", bus.match, (r_usr[7:0] == r_otp[7:0]));
         check("rnd_mismatch", bus.mismatch, (r_usr[7:0] != r_otp[7:0]));
      end

      // asynchronous reset in DONE
      check("t7_pre_reset_state", bus.fsm_state, S_DONE);
      #2;
      reset_n = 1'b0;
      #1;
      check("t7_async_reset_outs", 32'(outs()), 0);
      check("t7_async_reset_state", bus.fsm_state, S_IDLE);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      check("t7_after_release", 32'(outs()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
